// File: rtl/gpio_mmio_v2_pkg.sv
// gpio_pkg: shared constants for the memory-mapped GPIO peripheral
//   control-block offsets, default base indices and reset values
package gpio_pkg;
   localparam int IRQ_EN_OFS    = 0;
   localparam int IRQ_PEND_OFS  = 1;
   localparam int FREEZE_OFS    = 2;
   localparam int DEF_IN_BASE   = 32;
   localparam int DEF_CTRL_BASE = 48;
   localparam logic [31:0] RST_WORD = 32'h0000_0000;
endpackage

// File: rtl/gpio_mmio_v2_if.sv
// gpio_mmio_v2_if: CPU data-bus bundle for the GPIO peripheral
//   wr_en/addr/dat_i from the CPU, dat_o (combinational read data) and irq back to it
interface gpio_mmio_v2_if;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        irq;
   modport master (output wr_en, addr, dat_i, input dat_o, irq);
   modport slave  (input wr_en, addr, dat_i, output dat_o, irq);
endinterface

// File: rtl/gpio_mmio_v2_in_chan.sv
// gpio_in_chan: one input channel - 2-flop synchroniser, freezable hold register, change flag
//   clk, rst_n : clock, async active-low reset
//   din        : raw channel input
//   freeze     : hold dout while the synchroniser keeps sampling
//   dout       : readable channel value
//   chg        : synchronised value differs from dout and channel is not frozen
module gpio_in_chan #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   input  logic         freeze,
   output logic [W-1:0] dout,
   output logic         chg
);
   logic [W-1:0] sync1, sync2;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         dout  <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         if (!freeze) dout <= sync2;
      end
   end
   assign chg = (sync2 != dout) && !freeze;
endmodule

// File: rtl/gpio_mmio_v2.sv
// gpio_mmio_v2: memory-mapped GPIO with output registers, synchronised input channels and irq
//   clk, rst_n : clock, async active-low reset
//   bus        : CPU bus slave (wr_en, addr, dat_i in; dat_o, irq out)
//   in_bus     : NUM_IN packed input channels
//   out_bus    : NUM_OUT packed output registers
module gpio_mmio_v2
   import gpio_pkg::*;
#(
   parameter int NUM_OUT   = 14,
   parameter int OUT_W     = 8,
   parameter int NUM_IN    = 3,
   parameter int IN_W      = 16,
   parameter int ADDR_W    = 6,
   parameter int IN_BASE   = DEF_IN_BASE,
   parameter int CTRL_BASE = DEF_CTRL_BASE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   gpio_mmio_v2_if.slave            bus,
   input  logic [NUM_IN*IN_W-1:0]   in_bus,
   output logic [NUM_OUT*OUT_W-1:0] out_bus
);
   logic [ADDR_W-1:0] idx;
   logic [OUT_W-1:0]  out_r [NUM_OUT];
   logic [IN_W-1:0]   in_val [NUM_IN];
   logic [NUM_IN-1:0] chg, irq_en, pend, frz, clr;
   logic              wr_ien, wr_pend, wr_frz, unused_bits;
   logic [31:0]       rd;
   assign idx         = bus.addr[ADDR_W-1:0];
   assign wr_ien      = bus.wr_en && idx == ADDR_W'(CTRL_BASE + IRQ_EN_OFS);
   assign wr_pend     = bus.wr_en && idx == ADDR_W'(CTRL_BASE + IRQ_PEND_OFS);
   assign wr_frz      = bus.wr_en && idx == ADDR_W'(CTRL_BASE + FREEZE_OFS);
   assign clr         = wr_pend ? bus.dat_i[NUM_IN-1:0] : '0;
   assign unused_bits = ^{bus.addr, bus.dat_i};
   genvar j, k;
   for (j = 0; j < NUM_OUT; j++) begin : g_out
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) out_r[j] <= OUT_W'(RST_WORD);
         else if (bus.wr_en && idx == ADDR_W'(j)) out_r[j] <= bus.dat_i[OUT_W-1:0];
      end
      assign out_bus[j*OUT_W +: OUT_W] = out_r[j];
   end
   for (k = 0; k < NUM_IN; k++) begin : g_in
      gpio_in_chan #(.W(IN_W)) u_chan (
         .clk    (clk),
         .rst_n  (rst_n),
         .din    (in_bus[k*IN_W +: IN_W]),
         .freeze (frz[k]),
         .dout   (in_val[k]),
         .chg    (chg[k])
      );
   end
   // A set on the same edge as a write-1 clear wins because the OR is applied last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en <= NUM_IN'(RST_WORD);
         pend   <= NUM_IN'(RST_WORD);
         frz    <= NUM_IN'(RST_WORD);
      end else begin
         if (wr_ien) irq_en <= bus.dat_i[NUM_IN-1:0];
         if (wr_frz) frz <= bus.dat_i[NUM_IN-1:0];
         pend <= (pend & ~clr) | (chg & irq_en);
      end
   end
   always_comb begin
      rd = '0;
      for (int o = 0; o < NUM_OUT; o++) if (idx == ADDR_W'(o)) rd = 32'(out_r[o]);
      for (int i = 0; i < NUM_IN; i++) if (idx == ADDR_W'(IN_BASE + i)) rd = 32'(in_val[i]);
      rd = idx == ADDR_W'(CTRL_BASE + IRQ_EN_OFS)   ? 32'(irq_en) :
           idx == ADDR_W'(CTRL_BASE + IRQ_PEND_OFS) ? 32'(pend)   :
           idx == ADDR_W'(CTRL_BASE + FREEZE_OFS)   ? 32'(frz)    : rd;
   end
   assign bus.dat_o = rd;
   assign bus.irq   = |(pend & irq_en);
endmodule

// File: tb/tb_gpio_mmio_v2.sv
// tb_gpio_mmio_v2: directed scoreboard bench for gpio_mmio_v2
module tb_gpio_mmio_v2;
   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [47:0]   in_bus = '0;
   logic [111:0]  out_bus;
   logic [111:0]  exp_out = '0;
   int            total = 0;
   int            bad = 0;
   typedef struct {string tag; logic [127:0] v;} exp_t;
   exp_t          q[$];
   gpio_mmio_v2_if bus();
   gpio_mmio_v2 dut (.clk(clk), .rst_n(rst_n), .bus(bus), .in_bus(in_bus), .out_bus(out_bus));
   always #5 clk = ~clk;
   task automatic expect_v(input string tag, input logic [127:0] v);
      exp_t e;
      e.tag = tag;
      e.v = v;
      q.push_back(e);
   endtask
   task automatic check(input logic [127:0] obs);
      exp_t e;
      total++;
      if (q.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
         end
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input int a, input logic [31:0] d);
      bus.wr_en = 1'b1;
      bus.addr = 32'(a);
      bus.dat_i = d;
      tick();
      bus.wr_en = 1'b0;
      bus.dat_i = '0;
   endtask
   task automatic rd(input string tag, input int a, input logic [31:0] v);
      bus.addr = 32'(a);
      expect_v(tag, 128'(v));
      #1;
      check(128'(bus.dat_o));
   endtask
   task automatic chk_irq(input string tag, input logic v);
      expect_v(tag, 128'(v));
      check(128'(bus.irq));
   endtask
   task automatic chk_out(input string tag);
      expect_v(tag, 128'(exp_out));
      check(128'(out_bus));
   endtask
   initial begin
      bus.wr_en = 1'b0;
      bus.addr = '0;
      bus.dat_i = '0;
      tick();
      wr(0, 32'h55);
      #3;
      rst_n = 1'b0;
      #1;
      chk_out("rst_out_async");
      chk_irq("rst_irq_async", 1'b0);
      rd("rst_rd0", 0, 32'h0);
      rd("rst_rd13", 13, 32'h0);
      rd("rst_rd32", 32, 32'h0);
      rd("rst_rd49", 49, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      wr(5, 32'h1234_00A7);
      exp_out[47:40] = 8'hA7;
      chk_out("wr5_out");
      rd("wr5_rd", 5, 32'h0000_00A7);
      wr(40, 32'hFF);
      chk_out("wr40_ignored_out");
      rd("wr40_rd", 40, 32'h0);
      rd("wr40_ien", 48, 32'h0);
      wr(51, 32'h7);
      rd("wr51_frz", 50, 32'h0);
      rd("wr51_rd", 51, 32'h0);
      wr(48, 32'h1);
      in_bus[15:0] = 16'h0140;
      tick();
      rd("ch0_e1", 32, 32'h0);
      tick();
      rd("ch0_e2", 32, 32'h0);
      rd("ch0_e2_pend", 49, 32'h0);
      tick();
      rd("ch0_e3", 32, 32'h0140);
      rd("ch0_e3_pend", 49, 32'h1);
      chk_irq("ch0_e3_irq", 1'b1);
      wr(49, 32'h1);
      rd("clr_pend", 49, 32'h0);
      chk_irq("clr_irq", 1'b0);
      in_bus[15:0] = 16'h0141;
      tick();
      tick();
      wr(49, 32'h1);
      rd("setwins_pend", 49, 32'h1);
      chk_irq("setwins_irq", 1'b1);
      rd("setwins_val", 32, 32'h0141);
      wr(49, 32'h0);
      rd("wr0_noclr", 49, 32'h1);
      wr(49, 32'h1);
      rd("clr2_pend", 49, 32'h0);
      wr(48, 32'h2);
      wr(50, 32'h2);
      in_bus[31:16] = 16'h00F0;
      repeat (4) tick();
      rd("frz_hold", 33, 32'h0);
      rd("frz_pend", 49, 32'h0);
      chk_irq("frz_irq", 1'b0);
      rd("frz_reg", 50, 32'h2);
      wr(50, 32'h0);
      rd("unfrz_e0", 33, 32'h0);
      tick();
      rd("unfrz_val", 33, 32'h00F0);
      rd("unfrz_pend", 49, 32'h2);
      chk_irq("unfrz_irq", 1'b1);
      wr(48, 32'h3);
      in_bus[15:0] = 16'h0142;
      repeat (3) tick();
      wr(0, 32'h55);
      exp_out[7:0] = 8'h55;
      rd("pre_rst_pend", 49, 32'h3);
      chk_out("pre_rst_out");
      #3;
      rst_n = 1'b0;
      #1;
      exp_out = '0;
      chk_out("mid_rst_out");
      chk_irq("mid_rst_irq", 1'b0);
      rd("mid_rst_pend", 49, 32'h0);
      tick();
      rst_n = 1'b1;
      rd("post_rst_rd32", 32, 32'h0);
      tick();
      rd("post_rst_pend", 49, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gpio_mmio_v2.md
Name: gpio_mmio_v2

Overview:
Parametrised memory-mapped GPIO peripheral on the CPU data bus. It provides NUM_OUT writable/readable output registers that drive display digits and similar sinks, and NUM_IN read-only input channels such as mouse X, mouse Y and click.
Each input channel has a synchroniser, a per-channel freeze (snapshot) control, change detection, and sticky interrupt-pending bits cleared by writing 1. Pending and enabled channels are combined into a single irq line to the CPU.

Parameters:
NUM_OUT, 14, number of output registers
OUT_W, 8, width of each output register (≤32)
NUM_IN, 3, number of input channels (≤32)
IN_W, 16, width of each input channel (≤32)
ADDR_W, 6, number of low address bits decoded; index = addr[ADDR_W-1:0]
IN_BASE, 32, index of input channel 0
CTRL_BASE, 48, index of the control block: +0 IRQ_EN, +1 IRQ_PEND, +2 FREEZE

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  bus write strobe, one cycle per write
addr  in  32  bus address; only addr[ADDR_W-1:0] is decoded
dat_i  in  32  bus write data
in_bus  in  NUM_IN*IN_W  input channels; channel k occupies [k*IN_W +: IN_W]
out_bus  out  NUM_OUT*OUT_W  output registers; register j occupies [j*OUT_W +: OUT_W]
dat_o  out  32  bus read data, combinational from addr
irq  out  1  interrupt request, level, = |(pend & irq_en)

Behaviour:
- Reset: one clock domain, clk; asynchronous active-low reset rst_n.
  - Asserting rst_n clears all state immediately, with no clock edge needed: output regs, sync stages, in_reg, irq_en, pend and freeze all go to 0; irq = 0.
  - Deassertion is synchronous to clk at the source.
  - Reset mid-operation discards pending bits and any in-flight samples.
- Output write: on wr_en with index j < NUM_OUT, out[j] <= dat_i[OUT_W-1:0] at that edge; out_bus reflects the new value after the edge.
- Writes to input indices, unmapped indices or CTRL_BASE+3 and above are ignored.
- Input path, per channel k:
  - sync1 <= in_bus[k]; sync2 <= sync1; in_reg <= sync2 unless freeze[k].
  - Source holds in_bus stable ≥3 cycles; the synchroniser is a metastability guard only.
  - Latency from in_bus change to readable value: 3 clk edges.
- Change detect: chg[k] = (sync2 != in_reg) & ~freeze[k], any bit. On an edge with chg[k] & irq_en[k], pend[k] <= 1.
  - Changes while disabled or frozen never set pend.
- IRQ_EN (CTRL+0): R/W, bits [NUM_IN-1:0]; upper bits write-ignored, read 0.
- IRQ_PEND (CTRL+1): read returns pend.
  - Writing dat_i[k]=1 clears pend[k]; writing 0 has no effect.
  - If set and clear hit the same edge, set wins.
- FREEZE (CTRL+2): R/W.
  - freeze[k]=1 holds in_reg[k] while sync stages keep sampling.
  - On clearing freeze, in_reg loads sync2 at the next edge. If the values differ and the channel is enabled, pend is set at that edge.
- Input updates continue during bus writes; there is no blocking.
- Read map (dat_o, zero-extended, combinational):
  - j < NUM_OUT: out[j]
  - IN_BASE+k: in_reg[k]
  - CTRL+0..2: the corresponding control register
  - anything else: 0
- irq: combinational OR of flop outputs. It rises after the edge that sets pend and falls after the edge that clears pend or irq_en.
- Elaboration constraints: NUM_OUT ≤ IN_BASE; IN_BASE+NUM_IN ≤ CTRL_BASE; CTRL_BASE+2 < 2**ADDR_W.

Decomposition:
- Package gpio_pkg holds:
  - CTRL offsets: IRQ_EN_OFS=0, IRQ_PEND_OFS=1, FREEZE_OFS=2
  - default IN_BASE and CTRL_BASE
  - reset constants
- Sub-module gpio_in_chan contains:
  - 2-flop sync, hold register with freeze, change detect
  - ports: clk, rst_n, din, freeze, dout, chg
  - instantiated NUM_IN times in a generate loop
- Top level holds the address decode, output regs, pend/en/freeze and the read mux.

Test Plan:
1. Reset with rst_n=0 asserted between clock edges -> out_bus=0, irq=0 immediately; reads at index 0, 13, 32 and 49 return 0x00000000.
2. Write index 5 with 0x123400A7 -> out_bus[47:40]=0xA7 after the edge; read index 5 = 0x000000A7. Write index 40 with 0xFF -> no register changes.
3. IRQ_EN=0x1, then ch0 in_bus 0x0000→0x0140 -> index 32 reads 0x0140 from the 3rd edge; pend=0x1 and irq=1 after that same edge.
4. Write IRQ_PEND=0x1 -> pend=0 and irq=0 after the edge. Repeat with ch0 changing to 0x0141 so the clear hits the same set edge -> pend stays 0x1.
5. IRQ_EN=0x2, FREEZE=0x2, ch1 0x0000→0x00F0 -> index 33 stays 0x0000 and pend=0. Write FREEZE=0 -> next edge index 33=0x00F0 and pend=0x2.
6. With pend=0x3 and out[0]=0x55, assert rst_n mid-cycle -> pend, irq and out_bus all 0 without a clock edge; after release, the first read of index 32 returns 0.
